alu_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one combinational ALU datapath (ALU core plus flag calculator) between two requesters. It accepts one operation at a time via valid/ready, drives the ALU from registered operands, captures result and NVZC flags, and returns a tagged response with backpressure. It sits between the instruction/test-harness requesters and the ALU datapath, and is the only driver of the ALU opcode and operand inputs.

---
 rtl/alu_ops_pkg.sv | 19 +
 rtl/alu_rr_grant2.sv | 23 ++
 rtl/alu_share_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// Shared ALU opcode encodings, flag bit positions and sequencer state type.
package alu_ops;

   localparam int unsigned ADD_OP = 0;
   localparam int unsigned SUB_OP = 1;

   // Bit positions inside a packed {N,V,Z,C} flag vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_V = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_C = 0;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } share_state_t;

endpackage

// File: rtl/alu_rr_grant2.sv
// Combinational two-way round-robin grant.
module alu_rr_grant2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       grant_idx
);

   // On a tie favour the requester that was not served last; otherwise the sole requester.
   always_comb begin
      grant_idx = 1'b0;
      if (req_valid == 2'b11) begin
         grant_idx = ~last_grant;
      end else if (req_valid[1]) begin
         grant_idx = 1'b1;
      end
      grant = 2'b00;
      if (|req_valid) begin
         grant = grant_idx ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU datapath between two requesters and returns tagged responses.
module alu_share_ctrl
   import alu_ops::*;
#(
   parameter int unsigned W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*W-1:0] req_opcode,
   input  logic [2*W-1:0] req_a,
   input  logic [2*W-1:0] req_b,
   output logic [W-1:0]   alu_opcode,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   input  logic [W-1:0]   alu_result,
   input  logic           alu_negative,
   input  logic           alu_overflow,
   input  logic           alu_zero,
   input  logic           alu_cout,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_result,
   output logic [3:0]     rsp_flags,
   output logic           rsp_err
);

   share_state_t   state_q;
   logic           last_grant_q;
   logic           issue_cnt_q;
   logic [W-1:0]   alu_opcode_q, alu_a_q, alu_b_q;
   logic           rsp_valid_q, rsp_id_q, rsp_err_q;
   logic [W-1:0]   rsp_result_q;
   logic [3:0]     rsp_flags_q;

   logic [1:0]     grant;
   logic           grant_idx;
   logic [W-1:0]   sel_opcode, sel_a, sel_b;
   logic           op_err;
   logic [3:0]     cap_flags;

   alu_rr_grant2 u_grant (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   // Ready only to the granted requester while idle; forced low during reset.
   always_comb begin
      req_ready = 2'b00;
      if (rst_n && (state_q == StIdle)) begin
         req_ready = grant;
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      sel_opcode = grant_idx ? req_opcode[2*W-1:W] : req_opcode[W-1:0];
      sel_a      = grant_idx ? req_a[2*W-1:W]      : req_a[W-1:0];
      sel_b      = grant_idx ? req_b[2*W-1:W]      : req_b[W-1:0];
   end

   // Error decode and flag capture; V and C are meaningless for unsupported opcodes.
   always_comb begin
      op_err            = !((alu_opcode_q == W'(ADD_OP)) || (alu_opcode_q == W'(SUB_OP)));
      cap_flags         = 4'b0000;
      cap_flags[FLAG_N] = alu_negative;
      cap_flags[FLAG_V] = op_err ? 1'b0 : alu_overflow;
      cap_flags[FLAG_Z] = alu_zero;
      cap_flags[FLAG_C] = op_err ? 1'b0 : alu_cout;
   end

   // Sequencer FSM: accept, two-cycle issue window, then hold the response until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         issue_cnt_q  <= 1'b0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= 4'b0000;
         rsp_err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (|req_valid) begin
                  alu_opcode_q <= sel_opcode;
                  alu_a_q      <= sel_a;
                  alu_b_q      <= sel_b;
                  rsp_id_q     <= grant_idx;
                  last_grant_q <= grant_idx;
                  issue_cnt_q  <= 1'b0;
                  state_q      <= StIssue;
               end
            end
            StIssue: begin
               if (!issue_cnt_q) begin
                  issue_cnt_q <= 1'b1;
               end else begin
                  issue_cnt_q  <= 1'b0;
                  rsp_result_q <= alu_result;
                  rsp_flags_q  <= cap_flags;
                  rsp_err_q    <= op_err;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, table-driven vectors and a response scoreboard.
module tb_alu_share_ctrl;
   import alu_ops::*;

   localparam int unsigned W = 4;

   logic           clk;
   logic           rst_n;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_opcode, req_a, req_b;
   logic [W-1:0]   alu_opcode, alu_a, alu_b, alu_result;
   logic           alu_negative, alu_overflow, alu_zero, alu_cout;
   logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [W-1:0]   rsp_result;
   logic [3:0]     rsp_flags;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic         id;
      logic [W-1:0] result;
      logic [3:0]   flags;
      logic         err;
   } exp_t;

   typedef struct {
      int           id;
      logic [W-1:0] op, a, b, res;
      logic [3:0]   flags;
      logic         err;
   } vec_t;

   exp_t sbq[$];
   int   grant_log[$];
   vec_t tbl[7];

   alu_share_ctrl #(.W(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_opcode   (req_opcode),
      .req_a        (req_a),
      .req_b        (req_b),
      .alu_opcode   (alu_opcode),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_negative (alu_negative),
      .alu_overflow (alu_overflow),
      .alu_zero     (alu_zero),
      .alu_cout     (alu_cout),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_flags    (rsp_flags),
      .rsp_err      (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: {result, N, V, Z, C}. Unsupported opcodes do AND and raise V and C.
   function automatic logic [W+3:0] alu_calc(input logic [W-1:0] op, a, b);
      logic [W:0] s;
      logic       v;
      if (op == W'(ADD_OP)) begin
         s = {1'b0, a} + {1'b0, b};
         v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end else if (op == W'(SUB_OP)) begin
         s = {1'b0, a} + {1'b0, ~b} + 1'b1;
         v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         s = {1'b1, a & b};
         v = 1'b1;
      end
      return {s[W-1:0], s[W-1], v, (s[W-1:0] == '0), s[W]};
   endfunction

   assign {alu_result, alu_negative, alu_overflow, alu_zero, alu_cout} =
      alu_calc(alu_opcode, alu_a, alu_b);

   function automatic exp_t model(input logic id, input logic [W-1:0] op, a, b);
      logic [W+3:0] r;
      exp_t         e;
      r        = alu_calc(op, a, b);
      e.id     = id;
      e.result = r[W+3:4];
      e.err    = !((op == W'(ADD_OP)) || (op == W'(SUB_OP)));
      e.flags  = {r[3], r[2] & !e.err, r[1], r[0] & !e.err};
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [W-1:0] op, a, b);
      req_valid[id]         = 1'b1;
      req_opcode[id*W +: W] = op;
      req_a[id*W +: W]      = a;
      req_b[id*W +: W]      = b;
   endtask

   // Waits for req_ready[id], then returns #1 after the accept edge.
   task automatic wait_accept(input int id, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!rsp_valid && (sbq.size() == 0)) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain", 32'(done), 32'd1);
   endtask

   // Monitor: grant sanity, push expectations on accept, pop and compare on response handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
      end else begin
         if (req_ready != 2'b00) begin
            chk("ready_onehot", 32'((req_ready & (req_ready - 2'd1)) == 2'b00), 32'd1);
            chk("ready_to_valid", 32'(req_ready & ~req_valid), 32'd0);
            if (req_ready[1]) begin
               sbq.push_back(model(1'b1, req_opcode[2*W-1:W], req_a[2*W-1:W], req_b[2*W-1:W]));
               grant_log.push_back(1);
            end else begin
               sbq.push_back(model(1'b0, req_opcode[W-1:0], req_a[W-1:0], req_b[W-1:0]));
               grant_log.push_back(0);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
               chk("sb_rsp", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'(sbq.pop_front()));
            end
         end
      end
   end

   initial begin
      bit ok;
      // {id, op, a, b, result, {N,V,Z,C}, err}
      tbl[0] = '{0, 4'h0, 4'h3, 4'h5, 4'h8, 4'b1100, 1'b0};
      tbl[1] = '{1, 4'h1, 4'h5, 4'h5, 4'h0, 4'b0011, 1'b0};
      tbl[2] = '{0, 4'hF, 4'h1, 4'h2, 4'h0, 4'b0010, 1'b1};
      tbl[3] = '{1, 4'h0, 4'h7, 4'h1, 4'h8, 4'b1100, 1'b0};
      tbl[4] = '{0, 4'h0, 4'hF, 4'h1, 4'h0, 4'b0011, 1'b0};
      tbl[5] = '{1, 4'h1, 4'h2, 4'h3, 4'hF, 4'b1000, 1'b0};
      tbl[6] = '{0, 4'h2, 4'hC, 4'hA, 4'h8, 4'b1000, 1'b1};

      rst_n      = 1'b0;
      req_valid  = 2'b11;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b1;

      // Reset state, with both requests asserted to show ready is forced low.
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
      chk("rst_rsp", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      rst_n     = 1'b1;

      // Single-requester vectors with latency and field checks.
      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         set_req(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
         wait_accept(tbl[i].id, ok);
         chk($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
         req_valid = 2'b00;
         repeat (2) begin
            @(negedge clk);
            chk($sformatf("vec%0d_issue_valid", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("vec%0d_issue_ready", i), 32'(req_ready), 32'd0);
         end
         @(negedge clk);
         chk($sformatf("vec%0d_latency", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(tbl[i].id));
         chk($sformatf("vec%0d_result", i), 32'(rsp_result), 32'(tbl[i].res));
         chk($sformatf("vec%0d_flags", i), 32'(rsp_flags), 32'(tbl[i].flags));
         chk($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(tbl[i].err));
         @(posedge clk);
         #1;
      end
      wait_drain();

      // Backpressure: response held 5 cycles with the other requester waiting.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      set_req(0, 4'h0, 4'h6, 4'h6);
      wait_accept(0, ok);
      chk("stall_accept", 32'(ok), 32'd1);
      req_valid = 2'b00;
      set_req(1, 4'h1, 4'h4, 4'h1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_fields", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}),
             32'({1'b0, 4'hC, 4'b1100, 1'b0}));
         chk("stall_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall_last_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("stall_resume", 32'(req_ready), 32'b10);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_drain();

      // Reset during ISSUE drops the operation.
      @(posedge clk);
      #1;
      set_req(0, 4'h1, 4'h5, 4'h3);
      wait_accept(0, ok);
      chk("rstmid_accept", 32'(ok), 32'd1);
      set_req(1, 4'h0, 4'h2, 4'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_ready", 32'(req_ready), 32'd0);
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
      chk("rstmid_rsp", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("rstmid_hold_valid", 32'(rsp_valid), 32'd0);
      end
      set_req(0, 4'h0, 4'h1, 4'h2);
      set_req(1, 4'h1, 4'h9, 4'h4);
      grant_log.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Both requesters continuously valid: alternate grants starting at requester 0.
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         #1;
         if (grant_log.size() >= 4) begin
            req_valid = 2'b00;
            ok = 1'b1;
            break;
         end
      end
      chk("rr_count", 32'(ok), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i < grant_log.size()) begin
            chk($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
         end else begin
            chk($sformatf("rr_grant%0d_missing", i), 32'd0, 32'd1);
         end
      end
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
